mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 58 +++++
 rtl/mem_bus_if.sv | 56 +++++
 rtl/mem_stage.sv | 94 +++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: memory/control op codes, exception codes,
// bus widths, bus FSM states and the MEM pipeline register layout.
package mem_stage_pkg;

    localparam int PC_W   = 30;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        MEM_OP_NOP = 2'd0,
        MEM_OP_LDW = 2'd1,
        MEM_OP_STW = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_LDCR = 2'd1,
        CTRL_OP_STCR = 2'd2,
        CTRL_OP_EXRT = 2'd3
    } ctrl_op_e;

    typedef enum logic [2:0] {
        ISA_EXP_NO_EXP     = 3'd0,
        ISA_EXP_EXT_INT    = 3'd1,
        ISA_EXP_UNDEF_INSN = 3'd2,
        ISA_EXP_OVERFLOW   = 3'd3,
        ISA_EXP_MISS_ALIGN = 3'd4,
        ISA_EXP_TRAP       = 3'd5,
        ISA_EXP_PRV_VIO    = 3'd6
    } isa_exp_e;

    typedef enum logic {
        BUS_IF_IDLE   = 1'b0,
        BUS_IF_ACCESS = 1'b1
    } bus_if_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              en;
        logic              br_flag;
        logic [1:0]        ctrl_op;
        logic [REG_W-1:0]  dst_addr;
        logic              gpr_we_n;
        logic [2:0]        exp_code;
        logic [DATA_W-1:0] out;
    } mem_reg_t;

    localparam mem_reg_t MEM_REG_BUBBLE = '{
        pc: '0, en: 1'b0, br_flag: 1'b0, ctrl_op: CTRL_OP_NOP,
        dst_addr: '0, gpr_we_n: 1'b1, exp_code: ISA_EXP_NO_EXP, out: '0
    };

    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Bus-side half of the MEM stage: word-alignment check and the two-state
// IDLE/ACCESS request FSM with zero-wait completion support.
module mem_bus_if
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              en,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        exp_code,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              bus_rdy,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic              mem_busy,
    output logic              miss_align
);

    bus_if_state_e state;
    logic aligned;
    logic no_exp;
    logic word_op;
    logic acc;

    assign aligned = is_word_aligned(addr[1:0]);
    assign no_exp  = (exp_code == ISA_EXP_NO_EXP);
    assign word_op = (mem_op == MEM_OP_LDW) || (mem_op == MEM_OP_STW);
    assign acc     = en && (mem_op != MEM_OP_NOP) && no_exp && aligned && !flush;

    // An earlier exception takes precedence over the alignment fault.
    assign miss_align = en && word_op && no_exp && !aligned;

    // Once in ACCESS the request is held regardless of flush until the slave answers.
    assign bus_req     = (state == BUS_IF_ACCESS) || acc;
    assign mem_busy    = bus_req && !bus_rdy;
    assign bus_addr    = addr[DATA_W-1:2];
    assign bus_rw      = (mem_op == MEM_OP_LDW);
    assign bus_wr_data = wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BUS_IF_IDLE;
        end else begin
            case (state)
                BUS_IF_IDLE:   if (acc && !bus_rdy) state <= BUS_IF_ACCESS;
                BUS_IF_ACCESS: if (bus_rdy) state <= BUS_IF_IDLE;
                default:       state <= BUS_IF_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues the data bus access for LDW/STW and holds the
// MEM pipeline register feeding write-back.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [PC_W-1:0]   EXPC,
    input  logic              EXEn,
    input  logic              EXBrFlag,
    input  logic [1:0]        EXMemOp,
    input  logic [DATA_W-1:0] EXMemWrData,
    input  logic [1:0]        EXCtrlOp,
    input  logic [REG_W-1:0]  EXDstAddr,
    input  logic              EXGPRWE_,
    input  logic [2:0]        EXExpCode,
    input  logic [DATA_W-1:0] EXOut,
    output logic              BusReq,
    output logic [ADDR_W-1:0] BusAddr,
    output logic              BusRW,
    output logic [DATA_W-1:0] BusWrData,
    input  logic [DATA_W-1:0] BusRdData,
    input  logic              BusRdy,
    output logic              MemBusy,
    output logic [PC_W-1:0]   MEMPC,
    output logic              MEMEn,
    output logic              MEMBrFlag,
    output logic [1:0]        MEMCtrlOp,
    output logic [REG_W-1:0]  MEMDstAddr,
    output logic              MEMGPRWE_,
    output logic [2:0]        MEMExpCode,
    output logic [DATA_W-1:0] MEMOut
);

    logic     miss_align;
    mem_reg_t mem_next;
    mem_reg_t mem_p0;

    mem_bus_if u_bus_if (
        .clk         (clk),
        .reset       (reset),
        .flush       (Flush),
        .en          (EXEn),
        .mem_op      (EXMemOp),
        .exp_code    (EXExpCode),
        .addr        (EXOut),
        .wr_data     (EXMemWrData),
        .bus_rdy     (BusRdy),
        .bus_req     (BusReq),
        .bus_addr    (BusAddr),
        .bus_rw      (BusRW),
        .bus_wr_data (BusWrData),
        .mem_busy    (MemBusy),
        .miss_align  (miss_align)
    );

    always_comb begin
        mem_next = '{
            pc: EXPC, en: EXEn, br_flag: EXBrFlag, ctrl_op: EXCtrlOp,
            dst_addr: EXDstAddr, gpr_we_n: EXGPRWE_, exp_code: EXExpCode,
            out: (EXMemOp == MEM_OP_LDW) ? BusRdData : EXOut
        };
        if (Flush) begin
            mem_next = MEM_REG_BUBBLE;
        end else if (miss_align) begin
            mem_next.ctrl_op  = CTRL_OP_NOP;
            mem_next.dst_addr = '0;
            mem_next.gpr_we_n = 1'b1;
            mem_next.exp_code = ISA_EXP_MISS_ALIGN;
            mem_next.out      = '0;
        end
    end

    // EX -> MEM boundary; load data is captured on the edge where BusRdy releases the stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_p0 <= MEM_REG_BUBBLE;
        end else if (!Stall) begin
            mem_p0 <= mem_next;
        end
    end

    assign MEMPC      = mem_p0.pc;
    assign MEMEn      = mem_p0.en;
    assign MEMBrFlag  = mem_p0.br_flag;
    assign MEMCtrlOp  = mem_p0.ctrl_op;
    assign MEMDstAddr = mem_p0.dst_addr;
    assign MEMGPRWE_  = mem_p0.gpr_we_n;
    assign MEMExpCode = mem_p0.exp_code;
    assign MEMOut     = mem_p0.out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction stream checked against a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        gwe_n;
        logic [2:0]  exp;
        logic [31:0] out;
    } insn_t;

    logic clk = 1'b0, reset = 1'b1, stall_ext = 1'b0, Flush = 1'b0;
    logic Stall;
    logic [29:0] EXPC = '0;
    logic EXEn = 1'b0, EXBrFlag = 1'b0, EXGPRWE_ = 1'b1;
    logic [1:0] EXMemOp = '0, EXCtrlOp = '0;
    logic [31:0] EXMemWrData = '0, EXOut = '0, BusRdData = '0;
    logic [4:0] EXDstAddr = '0;
    logic [2:0] EXExpCode = '0;
    logic BusRdy = 1'b0;
    logic BusReq, BusRW, MemBusy, MEMEn, MEMBrFlag, MEMGPRWE_;
    logic [29:0] BusAddr, MEMPC;
    logic [31:0] BusWrData, MEMOut;
    logic [1:0] MEMCtrlOp;
    logic [4:0] MEMDstAddr;
    logic [2:0] MEMExpCode;

    int errors = 0;
    int checks = 0;

    localparam logic [74:0] RESET_VAL = {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};
    wire [74:0] mem_reg = {MEMPC, MEMEn, MEMBrFlag, MEMCtrlOp, MEMDstAddr, MEMGPRWE_, MEMExpCode, MEMOut};

    always #5 clk = ~clk;
    assign Stall = MemBusy | stall_ext;

    mem_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .EXPC(EXPC), .EXEn(EXEn), .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp),
        .EXMemWrData(EXMemWrData), .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr),
        .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode), .EXOut(EXOut),
        .BusReq(BusReq), .BusAddr(BusAddr), .BusRW(BusRW), .BusWrData(BusWrData),
        .BusRdData(BusRdData), .BusRdy(BusRdy), .MemBusy(MemBusy),
        .MEMPC(MEMPC), .MEMEn(MEMEn), .MEMBrFlag(MEMBrFlag), .MEMCtrlOp(MEMCtrlOp),
        .MEMDstAddr(MEMDstAddr), .MEMGPRWE_(MEMGPRWE_), .MEMExpCode(MEMExpCode),
        .MEMOut(MEMOut)
    );

    // Reference: what the MEM register must hold after an unstalled edge.
    function automatic logic [74:0] expected_mem(input insn_t i, input logic flush, input logic [31:0] rd);
        if (flush) return RESET_VAL;
        if (i.en && (i.op == MEM_OP_LDW || i.op == MEM_OP_STW) && i.exp == 3'd0 && i.out[1:0] != 2'b00)
            return {i.pc, i.en, i.br, 2'd0, 5'd0, 1'b1, 3'd4, 32'd0};
        return {i.pc, i.en, i.br, i.ctrl, i.dst, i.gwe_n, i.exp, (i.op == MEM_OP_LDW) ? rd : i.out};
    endfunction

    function automatic insn_t bubble();
        insn_t i;
        i = '0;
        i.gwe_n = 1'b1;
        return i;
    endfunction

    function automatic insn_t rand_insn();
        insn_t i;
        i.pc    = 30'($urandom);
        i.en    = ($urandom_range(0, 7) != 0);
        i.br    = 1'($urandom);
        i.op    = 2'($urandom_range(0, 2));
        i.wdata = $urandom;
        i.ctrl  = 2'($urandom);
        i.dst   = 5'($urandom);
        i.gwe_n = 1'($urandom);
        i.exp   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
        i.out   = $urandom;
        if (i.exp != 3'd0 || $urandom_range(0, 1) == 0) i.out[1:0] = 2'b00;
        return i;
    endfunction

    task automatic apply(input insn_t i);
        EXPC = i.pc; EXEn = i.en; EXBrFlag = i.br; EXMemOp = i.op; EXMemWrData = i.wdata;
        EXCtrlOp = i.ctrl; EXDstAddr = i.dst; EXGPRWE_ = i.gwe_n; EXExpCode = i.exp; EXOut = i.out;
    endtask

    task automatic go_idle();
        @(negedge clk);
        apply(bubble()); Flush = 1'b0; BusRdy = 1'b0; stall_ext = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; apply(bubble());
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_reg !== RESET_VAL) begin errors++; $display("FAIL reset_memreg got=%h exp=%h", mem_reg, RESET_VAL); end
        checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL reset_busreq got=%b exp=0", BusReq); end
        checks++; if (MemBusy !== 1'b0) begin errors++; $display("FAIL reset_membusy got=%b exp=0", MemBusy); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_load_zero_wait();
        insn_t i;
        i = bubble(); i.pc = 30'h100; i.en = 1'b1; i.op = MEM_OP_LDW; i.dst = 5'd3; i.gwe_n = 1'b0; i.out = 32'h100;
        @(negedge clk); apply(i); BusRdy = 1'b1; BusRdData = 32'hDEADBEEF; #1;
        checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL ld0_busreq got=%b exp=1", BusReq); end
        checks++; if (BusAddr !== 30'h40) begin errors++; $display("FAIL ld0_busaddr got=%h exp=40", BusAddr); end
        checks++; if (BusRW !== 1'b1) begin errors++; $display("FAIL ld0_busrw got=%b exp=1", BusRW); end
        checks++; if (MemBusy !== 1'b0) begin errors++; $display("FAIL ld0_membusy got=%b exp=0", MemBusy); end
        @(posedge clk); #1;
        checks++; if (MEMOut !== 32'hDEADBEEF) begin errors++; $display("FAIL ld0_memout got=%h exp=deadbeef", MEMOut); end
        checks++; if (mem_reg !== expected_mem(i, 1'b0, 32'hDEADBEEF)) begin errors++; $display("FAIL ld0_memreg got=%h exp=%h", mem_reg, expected_mem(i, 1'b0, 32'hDEADBEEF)); end
        go_idle();
    endtask

    task automatic test_store_wait();
        insn_t i;
        logic [74:0] prev;
        int busy_cycles;
        i = bubble(); i.pc = 30'h204; i.en = 1'b1; i.op = MEM_OP_STW; i.wdata = 32'h12345678; i.out = 32'h204;
        prev = mem_reg;
        busy_cycles = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); apply(i); BusRdy = 1'b0; #1;
            if (MemBusy === 1'b1) busy_cycles++;
            if (c == 0) begin
                checks++; if ({BusReq, BusRW, BusAddr, BusWrData} !== {1'b1, 1'b0, 30'h81, 32'h12345678}) begin
                    errors++; $display("FAIL st_bus got=%b/%b/%h/%h exp=1/0/81/12345678", BusReq, BusRW, BusAddr, BusWrData); end
            end
            @(posedge clk); #1;
            checks++; if (mem_reg !== prev) begin errors++; $display("FAIL st_hold_%0d got=%h exp=%h", c, mem_reg, prev); end
        end
        checks++; if (busy_cycles != 3) begin errors++; $display("FAIL st_busy_cycles got=%0d exp=3", busy_cycles); end
        @(negedge clk); BusRdy = 1'b1; #1;
        checks++; if ({BusReq, MemBusy} !== 2'b10) begin errors++; $display("FAIL st_done got=%b%b exp=10", BusReq, MemBusy); end
        @(posedge clk); #1;
        checks++; if (MEMOut !== 32'h204 || MEMEn !== 1'b1) begin errors++; $display("FAIL st_memout got=%h/%b exp=204/1", MEMOut, MEMEn); end
        go_idle();
    endtask

    task automatic test_misalign();
        insn_t i;
        i = bubble(); i.pc = 30'h3; i.en = 1'b1; i.op = MEM_OP_LDW; i.dst = 5'd7; i.gwe_n = 1'b0; i.ctrl = 2'd1; i.out = 32'h102;
        @(negedge clk); apply(i); BusRdy = 1'b0; #1;
        checks++; if ({BusReq, MemBusy} !== 2'b00) begin errors++; $display("FAIL mis_busreq got=%b%b exp=00", BusReq, MemBusy); end
        @(posedge clk); #1;
        checks++; if (MEMExpCode !== 3'd4 || MEMGPRWE_ !== 1'b1) begin errors++; $display("FAIL mis_exp got=%0d/%b exp=4/1", MEMExpCode, MEMGPRWE_); end
        checks++; if (mem_reg !== expected_mem(i, 1'b0, BusRdData)) begin errors++; $display("FAIL mis_memreg got=%h exp=%h", mem_reg, expected_mem(i, 1'b0, BusRdData)); end
        go_idle();
    endtask

    task automatic test_flush_during_access();
        insn_t i;
        i = bubble(); i.pc = 30'h50; i.en = 1'b1; i.op = MEM_OP_LDW; i.out = 32'h300;
        @(negedge clk); apply(i); Flush = 1'b1; BusRdy = 1'b0; #1;
        checks++; if (BusReq !== 1'b0) begin errors++; $display("FAIL flush_idle_req got=%b exp=0", BusReq); end
        @(negedge clk); Flush = 1'b0; i.op = MEM_OP_STW; i.wdata = 32'hCAFE0001; apply(i); #1;
        checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL flush_c1_req got=%b exp=1", BusReq); end
        @(negedge clk); Flush = 1'b1; #1;
        checks++; if ({BusReq, MemBusy} !== 2'b11) begin errors++; $display("FAIL flush_c2_req got=%b%b exp=11", BusReq, MemBusy); end
        @(negedge clk); BusRdy = 1'b1; #1;
        checks++; if (BusReq !== 1'b1) begin errors++; $display("FAIL flush_c3_req got=%b exp=1", BusReq); end
        @(posedge clk); #1;
        checks++; if (mem_reg !== RESET_VAL) begin errors++; $display("FAIL flush_bubble got=%h exp=%h", mem_reg, RESET_VAL); end
        go_idle();
    endtask

    task automatic test_reset_during_access();
        insn_t i;
        i = bubble(); i.pc = 30'h77; i.en = 1'b1; i.ctrl = 2'd2; i.dst = 5'd9; i.gwe_n = 1'b0; i.out = 32'h5A5A;
        @(negedge clk); apply(i); @(posedge clk);
        i.op = MEM_OP_STW; i.out = 32'h400;
        @(negedge clk); apply(i); BusRdy = 1'b0; @(posedge clk);
        @(negedge clk); reset = 1'b1; apply(bubble()); @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        checks++; if ({BusReq, MemBusy} !== 2'b00) begin errors++; $display("FAIL rst_acc_req got=%b%b exp=00", BusReq, MemBusy); end
        checks++; if (mem_reg !== RESET_VAL) begin errors++; $display("FAIL rst_acc_memreg got=%h exp=%h", mem_reg, RESET_VAL); end
        go_idle();
    endtask

    task automatic test_upstream_exc();
        insn_t i;
        i = bubble(); i.pc = 30'h99; i.en = 1'b1; i.op = MEM_OP_STW; i.exp = 3'd3; i.dst = 5'd2; i.out = 32'h10;
        @(negedge clk); apply(i); BusRdy = 1'b0; #1;
        checks++; if ({BusReq, MemBusy} !== 2'b00) begin errors++; $display("FAIL exc_busreq got=%b%b exp=00", BusReq, MemBusy); end
        @(posedge clk); #1;
        checks++; if (MEMExpCode !== 3'd3) begin errors++; $display("FAIL exc_code got=%0d exp=3", MEMExpCode); end
        checks++; if (mem_reg !== expected_mem(i, 1'b0, BusRdData)) begin errors++; $display("FAIL exc_memreg got=%h exp=%h", mem_reg, expected_mem(i, 1'b0, BusRdData)); end
        go_idle();
    endtask

    task automatic test_stall_hold();
        insn_t a, b;
        logic [74:0] held;
        a = bubble(); a.pc = 30'h1234; a.en = 1'b1; a.ctrl = 2'd3; a.dst = 5'd17; a.gwe_n = 1'b0; a.out = 32'hA5A5A5A5;
        b = bubble(); b.pc = 30'h4321; b.en = 1'b1; b.br = 1'b1; b.dst = 5'd4; b.gwe_n = 1'b0; b.out = 32'h0F0F0F0F;
        @(negedge clk); apply(a); @(posedge clk); #1;
        held = expected_mem(a, 1'b0, BusRdData);
        checks++; if (mem_reg !== held) begin errors++; $display("FAIL stall_load got=%h exp=%h", mem_reg, held); end
        @(negedge clk); stall_ext = 1'b1; Flush = 1'b1; apply(b); @(posedge clk); #1;
        checks++; if (mem_reg !== held) begin errors++; $display("FAIL stall_flush_hold got=%h exp=%h", mem_reg, held); end
        @(negedge clk); Flush = 1'b0; @(posedge clk); #1;
        checks++; if (mem_reg !== held) begin errors++; $display("FAIL stall_hold got=%h exp=%h", mem_reg, held); end
        @(negedge clk); stall_ext = 1'b0; @(posedge clk); #1;
        checks++; if (mem_reg !== expected_mem(b, 1'b0, BusRdData)) begin errors++; $display("FAIL stall_release got=%h exp=%h", mem_reg, expected_mem(b, 1'b0, BusRdData)); end
        go_idle();
    endtask

    task automatic test_random();
        insn_t i;
        logic flush, access;
        logic [31:0] rd;
        logic [74:0] prev;
        int waits;
        for (int n = 0; n < 200; n++) begin
            i = rand_insn();
            flush = ($urandom_range(0, 7) == 0);
            rd = $urandom;
            waits = $urandom_range(0, 3);
            access = i.en && i.op != MEM_OP_NOP && i.exp == 3'd0 && i.out[1:0] == 2'b00 && !flush;
            if (access) begin
                for (int c = 0; c <= waits; c++) begin
                    prev = mem_reg;
                    @(negedge clk); apply(i); Flush = flush; BusRdy = (c == waits);
                    BusRdData = (c == waits) ? rd : $urandom; #1;
                    checks++; if ({BusReq, MemBusy} !== {1'b1, c != waits}) begin
                        errors++; $display("FAIL rnd%0d_req c%0d got=%b%b exp=1%b", n, c, BusReq, MemBusy, c != waits); end
                    if (c == 0) begin
                        checks++; if (BusAddr !== i.out[31:2] || BusRW !== (i.op == MEM_OP_LDW) || (i.op == MEM_OP_STW && BusWrData !== i.wdata)) begin
                            errors++; $display("FAIL rnd%0d_bus got=%h/%b/%h exp=%h/%b/%h", n, BusAddr, BusRW, BusWrData, i.out[31:2], i.op == MEM_OP_LDW, i.wdata); end
                    end
                    @(posedge clk); #1;
                    if (c != waits) begin
                        checks++; if (mem_reg !== prev) begin errors++; $display("FAIL rnd%0d_hold got=%h exp=%h", n, mem_reg, prev); end
                    end
                end
            end else begin
                @(negedge clk); apply(i); Flush = flush; BusRdy = 1'($urandom); BusRdData = rd; #1;
                checks++; if ({BusReq, MemBusy} !== 2'b00) begin errors++; $display("FAIL rnd%0d_noreq got=%b%b exp=00", n, BusReq, MemBusy); end
                @(posedge clk); #1;
            end
            checks++; if (mem_reg !== expected_mem(i, flush, rd)) begin
                errors++; $display("FAIL rnd%0d_memreg got=%h exp=%h", n, mem_reg, expected_mem(i, flush, rd)); end
        end
        go_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_misalign();
        test_flush_during_access();
        test_reset_during_access();
        test_upstream_exc();
        test_stall_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
